// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/sub path.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic element of the serial path.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one bit pair per clock through a single
// full_adder, LSB first, with ARM-style flags delivered on a done pulse.
module serial_add_sub
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, result_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum, fa_cout;
  logic             accept;
  logic             last_bit;
  logic             cin_msb;
  logic [WIDTH-1:0] final_sum;

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // A new op is taken whenever the engine is not mid-operation.
  assign accept    = start && (state != RUN);
  assign last_bit  = (state == RUN) && (count == LAST);
  // On the final RUN edge the carry flop holds the carry into the MSB.
  assign cin_msb   = carry;
  assign final_sum = {fa_sum, result_sr[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand load and per-bit shift of operands, partial result and carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a      <= '0;
      op_b      <= '0;
      result_sr <= '0;
      carry     <= 1'b0;
      count     <= '0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= (sub == OP_SUB) ? ~b : b;
      carry <= sub;
      count <= '0;
    end else if (state == RUN) begin
      op_a      <= op_a >> 1;
      op_b      <= op_b >> 1;
      result_sr <= final_sum;
      carry     <= fa_cout;
      count     <= count + CW'(1);
    end
  end

  // Result and flags are captured once, on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (last_bit) begin
      result    <= final_sum;
      carry_out <= fa_cout;
      overflow  <= cin_msb ^ fa_cout;
      zero      <= (final_sum == '0);
      negative  <= fa_sum;
    end
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Bit-serial adder/subtractor that sits directly above the 1-bit full_adder cell. It owns the carry flop, the operand shift registers and the bit counter, and it passes one bit pair plus the stored carry through a single full_adder instance each clock. It is the area-minimal add/sub path for the ALU datapath. It returns a WIDTH-bit result and ARM-style flags through a start/done handshake.

Parameters:
WIDTH, 64, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request pulse; sampled only when busy=0
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while the operation is in RUN
done  output  1  single-cycle pulse; result and flags are valid from this cycle
result  output  WIDTH  sum/difference; held until the next accepted start
carry_out  output  1  carry out of the MSB (for sub, 1 = no borrow)
overflow  output  1  signed overflow
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, result, carry_out, overflow, zero, negative all 0; counter and carry flop 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at a clock edge:
  - latch a into opA and (sub ? ~b : b) into opB;
  - set carry flop = sub;
  - set counter = 0;
  - go to RUN.
- RUN, each edge:
  - full_adder inputs are opA[0], opB[0] and the carry flop;
  - the sum bit shifts into result_sr[WIDTH-1]; result_sr, opA and opB shift right by 1;
  - carry flop takes carry_out;
  - counter increments.
- RUN at the edge where counter == WIDTH-1: capture the carry into the MSB as cin_msb, then go to DONE.
- DONE:
  - done=1 for exactly this one cycle;
  - result = result_sr;
  - carry_out = carry flop;
  - overflow = cin_msb XOR carry flop;
  - zero = (result_sr == 0);
  - negative = result_sr[WIDTH-1];
  - with no start, return to IDLE on the next edge.
- Latency: start sampled at edge N; done is high in the cycle after edge N+WIDTH (WIDTH cycles of RUN). Back-to-back ops: start asserted during DONE is accepted, so throughput is one op per WIDTH+1 cycles.
- busy=1 only in RUN. start during RUN is ignored: it is neither queued nor flagged.
- a, b and sub may change freely after the start edge; internal copies are used.
- Outputs result and flags update only on entry to DONE. They are stable in IDLE and during a following RUN, and are not cleared by a new start.
- Reset mid-RUN: abort immediately to IDLE with all outputs 0; no done pulse.
- Arithmetic is modulo 2^WIDTH.
- full_adder carries gate delays of at most ~300 ps per bit. Clock period must be ≥1000 ps; the bench uses 2000 ps.

Decomposition:
- Package serial_alu_pkg holds:
  - state enum type (IDLE, RUN, DONE);
  - a localparam function/constant for counter width, $clog2(WIDTH);
  - OP_ADD=1'b0 and OP_SUB=1'b1.
- The sole sub-module is the existing full_adder cell, instantiated once. The FSM, shift registers and flag logic stay in serial_add_sub.

Test Plan:
- WIDTH=8, a=0x7F, b=0x01, sub=0 -> done exactly 8 cycles after the start edge; result=0x80, carry_out=0, overflow=1, negative=1, zero=0.
- WIDTH=8, a=0xFF, b=0x01, sub=0 -> result=0x00, carry_out=1, overflow=0, zero=1, negative=0.
- WIDTH=8, sub=1 cases:
  - a=0x05, b=0x05 -> result=0x00, carry_out=1, zero=1.
  - a=0x03, b=0x05 -> result=0xFE, carry_out=0, negative=1, overflow=0.
- WIDTH=8: start again during RUN with different operands -> ignored; first result delivered unchanged. Then start during the DONE cycle -> accepted; second done arrives 9 cycles after the first.
- WIDTH=8: reset=0 asynchronously at cycle 4 of RUN -> all outputs 0 within the same cycle, no done pulse. After release, a=0x10, b=0x20, sub=0 -> result=0x30.
- WIDTH=64 random sweep (≥200 ops, mixed sub) against a reference model -> result, carry_out, overflow, zero and negative all match; done spacing is ≥65 cycles.
